// File: rtl/spart_driver_if.sv
// Client-side and SPART-side control signals of spart_driver.
// databus is a tristate and stays a plain inout port of the driver.
interface spart_driver_if;
  logic [1:0] tx_req;
  logic [7:0] tx_data0;
  logic [7:0] tx_data1;
  logic [1:0] tx_gnt;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       cfg_done;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (
    input  tx_req, tx_data0, tx_data1, rx_ready, rda, tbr,
    output tx_gnt, rx_data, rx_valid, rx_overrun, cfg_done, iocs, iorw, ioaddr
  );

  modport slave (
    output tx_req, tx_data0, tx_data1, rx_ready, rda, tbr,
    input  tx_gnt, rx_data, rx_valid, rx_overrun, cfg_done, iocs, iorw, ioaddr
  );
endinterface

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor, round-robins two TX requesters, forwards RX bytes.
// Optional feature macro LOOPBACK_ECHO_EN: every received byte is echoed ahead of client traffic.
module spart_driver #(
  parameter logic [15:0] BAUD_DIV = 16'd325
) (
  input  logic           clk,
  input  logic           rst,
  spart_driver_if.master bus,
  inout  wire  [7:0]     databus
);
  typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, TX_WR, TX_WAIT} state_t;

  state_t     r_state;
  logic       r_iocs;
  logic       r_iorw;
  logic [1:0] r_ioaddr;
  logic [7:0] r_dout;
  logic [1:0] r_tx_gnt;
  logic [7:0] r_tx_byte;
  logic       r_rr;
  logic [1:0] r_hold;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_rx_overrun;
  logic       r_cfg_done;

  logic       w_win;
  logic       w_rx_block;
  logic       w_rx_load;
  logic       w_echo_pend;
  logic [7:0] w_echo_byte;
  logic       w_echo_drop;

  // With both requests up the pointer decides; a lone request always wins.
  assign w_win      = (&bus.tx_req) ? r_rr : bus.tx_req[1];
  assign w_rx_block = r_rx_valid & ~bus.rx_ready;
  assign w_rx_load  = bus.rda & r_iorw & ~w_rx_block;

`ifdef LOOPBACK_ECHO_EN
  logic       r_echo_valid;
  logic [7:0] r_echo_byte;
  logic       w_echo_take;

  assign w_echo_pend = r_echo_valid;
  assign w_echo_byte = r_echo_byte;
  assign w_echo_take = r_echo_valid & bus.tbr & (r_state == IDLE);
  assign w_echo_drop = w_rx_load & r_echo_valid & ~w_echo_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_echo_valid <= 1'b0;
      r_echo_byte  <= '0;
    end else if (w_rx_load & ~w_echo_drop) begin
      r_echo_valid <= 1'b1;
      r_echo_byte  <= databus;
    end else if (w_echo_take) begin
      r_echo_valid <= 1'b0;
    end
  end
`else
  assign w_echo_pend = 1'b0;
  assign w_echo_byte = '0;
  assign w_echo_drop = 1'b0;
`endif

  // NOTE: outputs are registered, so each state's bus cycle appears one clock after the state is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CFG_LO;
      r_iocs     <= 1'b0;
      r_iorw     <= 1'b1;
      r_ioaddr   <= 2'b00;
      r_dout     <= '0;
      r_tx_gnt   <= '0;
      r_tx_byte  <= '0;
      r_rr       <= 1'b0;
      r_hold     <= '0;
      r_cfg_done <= 1'b0;
    end else begin
      // NOTE: tx_gnt defaults low every clock so any grant is exactly one cycle wide.
      r_tx_gnt <= '0;
      case (r_state)
        CFG_LO: begin
          r_iocs   <= 1'b1;
          r_iorw   <= 1'b0;
          r_ioaddr <= 2'b10;
          r_dout   <= BAUD_DIV[7:0];
          r_state  <= CFG_HI;
        end
        CFG_HI: begin
          r_iocs     <= 1'b1;
          r_iorw     <= 1'b0;
          r_ioaddr   <= 2'b11;
          r_dout     <= BAUD_DIV[15:8];
          r_cfg_done <= 1'b1;
          r_state    <= IDLE;
        end
        IDLE: begin
          r_iocs   <= 1'b0;
          r_iorw   <= 1'b1;
          r_ioaddr <= 2'b00;
          if (bus.tbr) begin
            if (w_echo_pend) begin
              r_tx_byte <= w_echo_byte;
              r_state   <= TX_WR;
            end else if (|bus.tx_req) begin
              r_tx_byte        <= w_win ? bus.tx_data1 : bus.tx_data0;
              r_tx_gnt[w_win]  <= 1'b1;
              r_rr             <= ~w_win;
              r_state          <= TX_WR;
            end
          end
        end
        TX_WR: begin
          r_iocs   <= 1'b1;
          r_iorw   <= 1'b0;
          r_ioaddr <= 2'b00;
          r_dout   <= r_tx_byte;
          r_hold   <= 2'd2;
          r_state  <= TX_WAIT;
        end
        TX_WAIT: begin
          r_iocs   <= 1'b0;
          r_iorw   <= 1'b1;
          r_ioaddr <= 2'b00;
          // Skip the write cycle itself and the cycle where the SPART still shows a stale tbr.
          if (r_hold != 2'd0) begin
            r_hold <= r_hold - 2'd1;
          end else if (bus.tbr) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= CFG_LO;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      if (w_rx_load) begin
        r_rx_data  <= databus;
        r_rx_valid <= 1'b1;
      end else if (bus.rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      // A byte is lost if the buffer is full or the bus is busy with one of our writes.
      if ((bus.rda & ~w_rx_load) | w_echo_drop) begin
        r_rx_overrun <= 1'b1;
      end
    end
  end

  assign databus        = (r_iocs & ~r_iorw) ? r_dout : 8'bz;
  assign bus.iocs       = r_iocs;
  assign bus.iorw       = r_iorw;
  assign bus.ioaddr     = r_ioaddr;
  assign bus.tx_gnt     = r_tx_gnt;
  assign bus.rx_data    = r_rx_data;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.rx_overrun = r_rx_overrun;
  assign bus.cfg_done   = r_cfg_done;
endmodule
